// File: rtl/rf_pkg.sv
// Shared types and constants for the decode/execute boundary behind the 16x16 register file.
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_SLT = 4'd8,
        OP_LUI = 4'd9,
        OP_LD  = 4'd10,
        OP_ST  = 4'd11,
        OP_BEQ = 4'd12,
        OP_BNE = 4'd13,
        OP_JMP = 4'd14,
        OP_NOP = 4'd15
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] rd;
        logic              rd_we;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

    // A later-stage writer targets a source this instruction actually reads.
    function automatic logic src_match(
        input logic              uses,
        input logic              we,
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] dst
    );
        return uses && we && (src == dst);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand hazard detection and MEM > WB > register-file operand select.
// Forwarding is compiled in only when ID_EX_FWD_EN is defined; otherwise any pending writer stalls.
module fwd_sel #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              i_uses,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_mem_data_ok,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_hz
);
    import rf_pkg::*;

    logic w_match_mem;
    logic w_match_wb;

    assign w_match_mem = src_match(i_uses, i_mem_we, i_addr, i_mem_addr);
    assign w_match_wb  = src_match(i_uses, i_wb_we, i_addr, i_wb_addr);

`ifdef ID_EX_FWD_EN
    // Youngest writer wins; a MEM load whose data is not final yet must stall.
    always_comb begin
        o_data = i_rf_data;
        o_hz   = 1'b0;
        if (w_match_mem) begin
            o_data = i_mem_data;
            o_hz   = !i_mem_data_ok;
        end else if (w_match_wb) begin
            o_data = i_wb_data;
            o_hz   = 1'b0;
        end else begin
            o_data = i_rf_data;
            o_hz   = 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_mem_data, i_mem_data_ok, i_wb_data};

    // Without bypass paths, wait until the writer has retired past WB.
    always_comb begin
        o_data = i_rf_data;
        o_hz   = 1'b0;
        if (w_match_mem || w_match_wb) begin
            o_hz = 1'b1;
        end else begin
            o_hz = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with RAW hazard resolution and a saturating stall counter.
// Optional operand forwarding from MEM/WB is enabled by defining ID_EX_FWD_EN.
module id_ex_stage #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int OP_W   = rf_pkg::OP_W,
    parameter int CNT_W  = rf_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [ADDR_W-1:0] in_a_addr,
    input  logic [ADDR_W-1:0] in_b_addr,
    input  logic              in_uses_a,
    input  logic              in_uses_b,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    input  logic              flush,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_ok,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_we,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [CNT_W-1:0]  stall_cnt
);
    import rf_pkg::*;

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_hz_a;
    logic              w_hz_b;
    logic              w_hz;
    logic              w_accept;
    id_ex_t            w_next_pl;

    id_ex_t            r_pl;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt;

    fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .i_uses        (in_uses_a),
        .i_addr        (in_a_addr),
        .i_rf_data     (rf_a),
        .i_mem_we      (mem_we),
        .i_mem_addr    (mem_addr),
        .i_mem_data    (mem_data),
        .i_mem_data_ok (mem_data_ok),
        .i_wb_we       (wb_we),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_data),
        .o_data        (w_a),
        .o_hz          (w_hz_a)
    );

    fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .i_uses        (in_uses_b),
        .i_addr        (in_b_addr),
        .i_rf_data     (rf_b),
        .i_mem_we      (mem_we),
        .i_mem_addr    (mem_addr),
        .i_mem_data    (mem_data),
        .i_mem_data_ok (mem_data_ok),
        .i_wb_we       (wb_we),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_data),
        .o_data        (w_b),
        .o_hz          (w_hz_b)
    );

    assign w_hz     = w_hz_a || w_hz_b;
    assign in_ready = !flush && !w_hz && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Assemble the payload captured on accept.
    always_comb begin
        w_next_pl       = '0;
        w_next_pl.op    = op_e'(in_op);
        w_next_pl.rd    = in_rd;
        w_next_pl.rd_we = in_rd_we;
        w_next_pl.a     = w_a;
        w_next_pl.b     = w_b;
        w_next_pl.imm   = in_imm;
    end

    // Flush beats accept; a consume without a new accept leaves a bubble.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_valid <= 1'b0;
            r_pl    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pl    <= w_next_pl;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Counts cycles a valid instruction is held back by a hazard; sticks at all-ones.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hz && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign out_valid = r_valid;
    assign out_op    = r_pl.op;
    assign out_rd    = r_pl.rd;
    assign out_rd_we = r_pl.rd_we;
    assign out_a     = r_pl.a;
    assign out_b     = r_pl.b;
    assign out_imm   = r_pl.imm;
    assign stall_cnt = r_stall_cnt;

endmodule
